fir_tap_pair_sequencer: RTL and testbench

Sample-history stage that feeds the pre-subtractor (n_bit_subtractor) of the antisymmetric FIR datapath. It keeps the last TAPS input samples in a circular buffer. For every accepted sample it emits TAPS/2 operand pairs (x[n-k], x[n-(TAPS-1-k)]), one per handshake, on a valid/ready stream. Downstream, the pairs drive the subtractor's in1/in2 and then the coefficient MAC.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_sample_ring.sv | 34 +++
 rtl/fir_tap_pair_sequencer.sv | 98 +++++++++
 tb/tb_fir_tap_pair_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the antisymmetric FIR datapath: sequencer state
// encoding, pointer sizing helper and default widths shared with the subtractor and MAC.
package fir_pkg;

  localparam int FIR_IN_DATAWIDTH = 8;
  localparam int FIR_TAPS         = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// Sample history ring: one write port, two combinational read ports,
// contents cleared asynchronously so unfilled history reads as zero.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int DW   = FIR_IN_DATAWIDTH,
  parameter int TAPS = FIR_TAPS,
  localparam int AW  = ptr_width(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr_a,
  output logic [DW-1:0] rd_data_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b
);

  logic [DW-1:0] mem [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/fir_tap_pair_sequencer.sv
// Emits TAPS/2 antisymmetric operand pairs (x[n-k], x[n-(TAPS-1-k)]) per
// accepted sample on a valid/ready stream feeding the pre-subtractor.
//
// state | meaning
// IDLE  | ready for a new sample, no pair on the output
// EMIT  | presenting pair k, advancing on each handshake
module fir_tap_pair_sequencer
  import fir_pkg::*;
#(
  parameter int IN_DATAWIDTH = FIR_IN_DATAWIDTH,
  parameter int TAPS         = FIR_TAPS,
  localparam int KW          = ptr_width(TAPS / 2),
  localparam int AW          = ptr_width(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [IN_DATAWIDTH-1:0] s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [IN_DATAWIDTH-1:0] m_in1,
  output logic [IN_DATAWIDTH-1:0] m_in2,
  output logic [KW-1:0]           m_tap_idx,
  output logic                    m_first,
  output logic                    m_last
);

  seq_state_t    state_q, state_d;
  logic [KW-1:0] k_q;
  logic [AW-1:0] wr_ptr_q, np_q;
  logic [AW-1:0] k_ext, rd_addr_a, rd_addr_b;
  logic          accept, last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) state_d = EMIT;
      end
      EMIT: begin
        m_valid = 1'b1;
        if (m_ready && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      wr_ptr_q <= '0;
      np_q     <= '0;
    end else if (accept) begin
      k_q      <= '0;
      np_q     <= wr_ptr_q;
      wr_ptr_q <= wr_ptr_q + AW'(1);
    end else if (state_q == EMIT && m_ready && !last) begin
      k_q <= k_q + KW'(1);
    end
  end

  // Power-of-two ring: pointer arithmetic wraps naturally at AW bits.
  assign k_ext     = AW'(k_q);
  assign rd_addr_a = np_q - k_ext;
  assign rd_addr_b = np_q + AW'(1) + k_ext;

  assign last      = (k_q == KW'(TAPS / 2 - 1));
  assign m_tap_idx = k_q;
  assign m_first   = (k_q == '0);
  assign m_last    = last;

  fir_sample_ring #(
    .DW   (IN_DATAWIDTH),
    .TAPS (TAPS)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (accept),
    .wr_addr   (wr_ptr_q),
    .wr_data   (s_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (m_in1),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (m_in2)
  );

endmodule

// File: tb/tb_fir_tap_pair_sequencer.sv
// Directed bench for the tap-pair sequencer at TAPS=4, IN_DATAWIDTH=8,
// with hand-computed pair values and an inline pre-subtractor model.
module tb_fir_tap_pair_sequencer;

  localparam int DW   = 8;
  localparam int TAPS = 4;
  localparam int KW   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_in1, m_in2;
  logic [KW-1:0] m_tap_idx;
  logic          m_first, m_last;

  int n_total = 0;
  int n_pass  = 0;

  fir_tap_pair_sequencer #(
    .IN_DATAWIDTH (DW),
    .TAPS         (TAPS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_in1     (m_in1),
    .m_in2     (m_in2),
    .m_tap_idx (m_tap_idx),
    .m_first   (m_first),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_pair(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int k);
    chk({tag, " m_valid"}, 32'(m_valid), 32'd1);
    chk({tag, " s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, " m_in1"}, 32'(m_in1), 32'(a));
    chk({tag, " m_in2"}, 32'(m_in2), 32'(b));
    chk({tag, " m_tap_idx"}, 32'(m_tap_idx), 32'(k));
    chk({tag, " m_first"}, 32'(m_first), (k == 0) ? 32'd1 : 32'd0);
    chk({tag, " m_last"}, 32'(m_last), (k == TAPS / 2 - 1) ? 32'd1 : 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Push one sample with m_ready high and check both pairs and the return to idle.
  task automatic push(input string tag, input logic [DW-1:0] d,
                      input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                      input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    int budget;
    budget = 0;
    while (!s_ready && budget < 20) begin
      step();
      budget++;
    end
    if (!s_ready) chk({tag, " s_ready wait timeout"}, 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    chk_pair({tag, " k0"}, a0, b0, 0);
    step();
    chk_pair({tag, " k1"}, a1, b1, 1);
    step();
    chk({tag, " s_ready back"}, 32'(s_ready), 32'd1);
    chk({tag, " m_valid low"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    logic [DW:0] diff;

    // Reset values
    #2;
    chk("rst s_ready", 32'(s_ready), 32'd1);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst m_in1", 32'(m_in1), 32'd0);
    chk("rst m_in2", 32'(m_in2), 32'd0);
    chk("rst m_tap_idx", 32'(m_tap_idx), 32'd0);
    chk("rst m_first", 32'(m_first), 32'd1);
    chk("rst m_last", 32'(m_last), 32'd0);
    do_reset();

    // Single sample into empty history
    push("p5", 8'd5, 8'd5, 8'd0, 8'd0, 8'd0);

    // Fill history 1..4
    do_reset();
    push("f1", 8'd1, 8'd1, 8'd0, 8'd0, 8'd0);
    push("f2", 8'd2, 8'd2, 8'd0, 8'd1, 8'd0);
    push("f3", 8'd3, 8'd3, 8'd0, 8'd2, 8'd1);
    push("f4", 8'd4, 8'd4, 8'd1, 8'd3, 8'd2);
    // Pointer wrap
    push("w5", 8'd5, 8'd5, 8'd2, 8'd4, 8'd3);
    push("w6", 8'd6, 8'd6, 8'd3, 8'd5, 8'd4);

    // Backpressure with a pending sample held on s_valid
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'd7;
    step();
    s_data = 8'd9;
    for (int i = 0; i < 3; i++) chk_pair("bp hold", 8'd7, 8'd0, 0);
    for (int i = 0; i < 3; i++) begin
      chk_pair("bp stall", 8'd7, 8'd0, 0);
      if (i < 2) step();
    end
    m_ready = 1'b1;
    step();
    chk_pair("bp k1", 8'd0, 8'd0, 1);
    step();
    chk("bp idle s_ready", 32'(s_ready), 32'd1);
    chk("bp idle m_valid", 32'(m_valid), 32'd0);
    step();
    s_valid = 1'b0;
    chk_pair("bp next k0", 8'd9, 8'd0, 0);
    step();
    chk_pair("bp next k1", 8'd7, 8'd0, 1);
    step();

    // Reset during k=1
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'd3;
    step();
    s_valid = 1'b0;
    step();
    chk_pair("mid k1", 8'd0, 8'd0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst m_valid", 32'(m_valid), 32'd0);
    chk("mid rst s_ready", 32'(s_ready), 32'd1);
    chk("mid rst m_tap_idx", 32'(m_tap_idx), 32'd0);
    chk("mid rst m_in1", 32'(m_in1), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    push("after rst", 8'd9, 8'd9, 8'd0, 8'd0, 8'd0);

    // Extremes through a pre-subtractor model
    do_reset();
    push("x255", 8'd255, 8'd255, 8'd0, 8'd0, 8'd0);
    push("x0a", 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
    push("x0b", 8'd0, 8'd0, 8'd0, 8'd0, 8'd255);
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'd0;
    step();
    s_valid = 1'b0;
    chk_pair("x0c k0", 8'd0, 8'd255, 0);
    diff = {1'b0, m_in1} - {1'b0, m_in2};
    chk("sub 0-255", 32'(diff), 32'h101);
    step();
    chk_pair("x0c k1", 8'd0, 8'd0, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
